dbus_uart_tx: RTL
=================

// Module: dbus_uart_tx
// PURPOSE
//   Memory-mapped UART transmitter; a responder on the CPU data bus beside ram.
//   CPU stores push bytes into a TX FIFO.
//   A serialiser shifts each byte out as 8N1, LSB first, at a programmable baud divisor.
//   Status is readable on dbus_read.
//   Registered read path gives the same one-cycle read latency as ram.
// PARAMETERS
//   BASE_ADDR   16'hF000  byte base of 16-byte register window; bits [3:0] must be 0
//   FIFO_AW     2         FIFO depth = 2**FIFO_AW entries of 8 bits
//   DEFAULT_DIV 16'd139   reset divisor; clk cycles per bit (16 MHz / 115200)
// PORTS
//   clk        in   1   system clock
//   rst        in   1   asynchronous, active-high reset
//   dbus_addr  in   16  byte address from cpu; bits [1:0] ignored
//   dbus_write in   32  store data from cpu
//   dbus_wen   in   1   store strobe; sampled on rising clk
//   dbus_read  out  32  registered read data; 0 when window not selected
//   tx         out  1   serial output; idle high
// BEHAVIOUR
//   Clocking and reset
//   - One clock. rst is asynchronous and active-high.
//   - Reset values: tx=1, dbus_read=0, FIFO empty, FSM IDLE, DIV=DEFAULT_DIV, OVF=0.
//   - Reset asserted mid-frame aborts the frame; tx returns high immediately.
//   Address decode
//   - sel = (dbus_addr[15:4] == BASE_ADDR[15:4]).
//   - Register offset = dbus_addr[3:2]: 0 DATA, 1 STATUS, 2 DIV, 3 reserved.
//   Writes (when sel && dbus_wen)
//   - DATA: push dbus_write[7:0] if the FIFO is not full.
//     If full, drop the byte and set OVF.
//     Full is judged before any same-cycle pop.
//   - STATUS: writing 1 to bit 3 clears OVF.
//     If an overflow and a clear happen in the same cycle, the overflow wins.
//   - DIV: DIV <= dbus_write[15:0]. Values below 2 are stored as 2.
//   Reads (one-cycle latency)
//   - dbus_read is updated every cycle from the address presented in the previous cycle.
//   - DATA reads 0.
//   - STATUS = {count[FIFO_AW:0] at [8+FIFO_AW:8], OVF[3], busy[2], empty[1], full[0]}, other bits 0.
//   - DIV reads {16'b0, DIV}. Reserved reads 0. Unselected reads 0.
//   FIFO
//   - Circular buffer with FIFO_AW-bit pointers that wrap mod depth.
//   - Count of FIFO_AW+1 bits.
//   - Push and pop in the same cycle leave count unchanged.
//   Serialiser FSM (baud counter bcnt, bit index bidx[2:0], shift register sh)
//   - IDLE: tx=1. When the FIFO is not empty: pop into sh, latch DIV into div_l,
//     bcnt=0, go to START.
//   - START: tx=0 for div_l cycles, then go to DATA with bidx=0.
//   - DATA: tx=sh[0] for div_l cycles, then shift right.
//     After bidx==7, go to STOP.
//   - STOP: tx=1 for div_l cycles, then go to IDLE.
//     Back-to-back frames: IDLE lasts exactly 1 cycle between frames.
//   - busy = (state != IDLE).
//   - A DIV write mid-frame takes effect from the next frame (div_l is frozen per frame).
//   - Frame length = 10*div_l cycles, plus 1 IDLE cycle between frames.
// CONFIGURATION
//   DBUS_UART_IRQ_EN defined
//   - Adds port irq (out, 1; reset 0).
//   - Adds CTRL register at offset 3: bit0 = IE (reset 0), read/write.
//   - irq is registered: irq <= IE && empty && !busy.
//     It stays high until data is pushed or IE is cleared.
//   DBUS_UART_IRQ_EN undefined
//   - No irq port.
//   - Offset 3 reads 0; writes to offset 3 are ignored.
// TESTING
//   1. Reset, then read STATUS at 0xF004 -> next-cycle dbus_read = 0x2 (empty); tx=1.
//   2. Write DIV=4, then DATA=0xA5 -> tx: 4 cycles low; bits 1,0,1,0,0,1,0,1 at 4 cycles each;
//      then 4 cycles high; busy is 1 throughout.
//   3. Push 5 bytes back-to-back with FIFO_AW=2 and DIV=4 ->
//      - The first byte is popped into sh on the cycle after its push.
//      - The next 4 bytes fill the FIFO, so all 5 are accepted and OVF=0.
//      - A 6th immediate push sets STATUS bit3 and drops 0x06.
//      - Writing STATUS 0x8 clears OVF.
//   4. Write DIV=0 -> DIV readback = 2.
//      Also: writing DIV=8 mid-frame leaves the current frame at its old rate;
//      the next frame uses 8 cycles per bit.
//   5. Assert rst during DATA bit 3 -> tx=1 and dbus_read=0 with no clock edge;
//      after release, FIFO is empty and DIV=139.
//   6. With DBUS_UART_IRQ_EN: write CTRL=1 while idle and empty -> irq=1 next cycle.
//      Push a byte -> irq=0 next cycle; irq rises again after the STOP bit completes.

Source files
------------

// File: rtl/dbus_uart_tx.sv
// dbus_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data bus.
//   Stores to DATA push bytes into a small TX FIFO. A serialiser pops each
//   byte and shifts it out LSB first at a programmable baud divisor.
//   STATUS and DIV are readable with the same one-cycle latency as ram.
// Register window (byte offsets from BASE_ADDR, addr[1:0] ignored):
//   0x0 DATA   (W) push byte, reads 0
//   0x4 STATUS (R) {count, OVF, busy, empty, full}; W1 to bit 3 clears OVF
//   0x8 DIV    (RW) clk cycles per bit, values below 2 stored as 2
//   0xC CTRL   (RW) bit0 = IE, only when DBUS_UART_IRQ_EN is defined;
//              otherwise reserved (reads 0, writes ignored)
// Build option: `define DBUS_UART_IRQ_EN adds the irq output and CTRL register.

module dbus_uart_tx #(
  parameter logic [15:0] BASE_ADDR   = 16'hF000,
  parameter int          FIFO_AW     = 2,
  parameter logic [15:0] DEFAULT_DIV = 16'd139
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dbus_addr,
  input  logic [31:0] dbus_write,
  input  logic        dbus_wen,
  output logic [31:0] dbus_read,
  output logic        tx
`ifdef DBUS_UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Bus decode
  logic       sel;
  logic [1:0] off;
  logic       wr_data;
  logic       wr_status;
  logic       wr_div;

  // FIFO
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Control registers
  logic        ovf;
  logic [15:0] div;

  // Serialiser
  state_t      state;
  state_t      state_n;
  logic [15:0] bcnt;
  logic [15:0] bcnt_n;
  logic [2:0]  bidx;
  logic [2:0]  bidx_n;
  logic [7:0]  sh;
  logic [7:0]  sh_n;
  logic [15:0] div_l;
  logic [15:0] div_l_n;
  logic        bit_end;
  logic        busy;

  logic [31:0] rdata_n;

`ifdef DBUS_UART_IRQ_EN
  logic ie;
  logic wr_ctrl;
`endif

  assign sel       = (dbus_addr[15:4] == BASE_ADDR[15:4]);
  assign off       = dbus_addr[3:2];
  assign wr_data   = sel && dbus_wen && (off == OFF_DATA);
  assign wr_status = sel && dbus_wen && (off == OFF_STATUS);
  assign wr_div    = sel && dbus_wen && (off == OFF_DIV);
`ifdef DBUS_UART_IRQ_EN
  assign wr_ctrl   = sel && dbus_wen && (off == OFF_CTRL);
`endif

  // Full is judged on the registered count, so a same-cycle pop never
  // makes room for a push into a full FIFO.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = wr_data && !full;
  assign busy  = (state != S_IDLE);

  assign bit_end = (bcnt == div_l - 16'd1);

  // FIFO storage: written on accepted pushes only.
  // NOTE: the storage array is deliberately not reset; valid entries are
  // tracked by the pointers and count, which are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= dbus_write[7:0];
    end
  end

  // FIFO pointers and occupancy count.
  // NOTE: state registers use non-blocking assignments so every flop sees
  // the pre-edge values of the others, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Overflow flag and baud divisor registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      div <= DEFAULT_DIV;
    end else begin
      // A dropped byte in the same cycle as a clear leaves OVF set.
      if (wr_data && full) begin
        ovf <= 1'b1;
      end else if (wr_status && dbus_write[3]) begin
        ovf <= 1'b0;
      end
      if (wr_div) begin
        div <= (dbus_write[15:0] < 16'd2) ? 16'd2 : dbus_write[15:0];
      end
    end
  end

  // Serialiser state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      bcnt  <= '0;
      bidx  <= '0;
      sh    <= '0;
      div_l <= DEFAULT_DIV;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      bidx  <= bidx_n;
      sh    <= sh_n;
      div_l <= div_l_n;
    end
  end

  // Serialiser next state, pop request and line level. tx decodes straight
  // from the state, so an asynchronous reset returns the line high at once.
  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    bidx_n  = bidx;
    sh_n    = sh;
    div_l_n = div_l;
    pop     = 1'b0;
    tx      = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = mem[rptr];
          div_l_n = div;
          bcnt_n  = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (bit_end) begin
          bcnt_n  = '0;
          bidx_n  = '0;
          state_n = S_DATA;
        end else begin
          bcnt_n = bcnt + 16'd1;
        end
      end
      S_DATA: begin
        tx = sh[0];
        if (bit_end) begin
          bcnt_n = '0;
          sh_n   = {1'b0, sh[7:1]};
          if (bidx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bidx_n = bidx + 3'd1;
          end
        end else begin
          bcnt_n = bcnt + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bcnt_n  = '0;
          state_n = S_IDLE;
        end else begin
          bcnt_n = bcnt + 16'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Read mux for the address presented this cycle; registered below.
  always_comb begin
    rdata_n = '0;
    if (sel) begin
      unique case (off)
        OFF_DATA: rdata_n = '0;
        OFF_STATUS: begin
          rdata_n[8+FIFO_AW:8] = count;
          rdata_n[3]           = ovf;
          rdata_n[2]           = busy;
          rdata_n[1]           = empty;
          rdata_n[0]           = full;
        end
        OFF_DIV: rdata_n = {16'b0, div};
        OFF_CTRL: begin
`ifdef DBUS_UART_IRQ_EN
          rdata_n[0] = ie;
`else
          rdata_n = '0;
`endif
        end
        default: rdata_n = '0;
      endcase
    end
  end

  // Registered read data, giving the bus one cycle of read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbus_read <= '0;
    end else begin
      dbus_read <= rdata_n;
    end
  end

`ifdef DBUS_UART_IRQ_EN
  // Interrupt enable and registered TX-drained interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ie <= dbus_write[0];
      end
      irq <= ie && empty && !busy;
    end
  end
`endif

endmodule
